fir_coeff_loader: RTL and testbench

- Runtime coefficient loader sitting directly upstream of the 4-tap systolic preadd filter; drives its four 18-bit coefficient inputs.
- Accepts coefficients as a 4-beat valid/ready stream into shadow registers.
- Transfers all four to the active outputs atomically on a commit strobe aligned to the filter's update boundary, so the filter never sees a mixed coefficient set.
- Rejects and reports malformed loads.

---
 rtl/fir_coeff_loader.sv | 120 ++++++++++++
 tb/tb_fir_coeff_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Runtime coefficient loader for the 4-tap systolic preadd filter: collects a
// 4-beat coefficient stream into shadow registers and commits all four at once.
module fir_coeff_loader #(
    parameter string       AUTO_COMMIT = "FALSE",
    parameter logic [17:0] INIT0       = 18'h0,
    parameter logic [17:0] INIT1       = 18'h0,
    parameter logic [17:0] INIT2       = 18'h0,
    parameter logic [17:0] INIT3       = 18'h0,
    parameter string       CLKTYPE     = "NONE"
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [17:0] s_dat_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    input  logic        update_i,
    output logic [17:0] coeff0_o,
    output logic [17:0] coeff1_o,
    output logic [17:0] coeff2_o,
    output logic [17:0] coeff3_o,
    output logic        pending_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned DW   = 18;
    localparam int unsigned NTAP = 4;
    localparam bit          AUTO = (AUTO_COMMIT == "TRUE");

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        PENDING
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [DW-1:0] shadow [NTAP];
    logic          accept;
    logic          commit;

    // The clock-type tag only annotates the output registers for downstream tools.
    if (CLKTYPE != "NONE") begin : g_clktype_tagged
    end

    assign accept = s_valid_i && s_ready_o;
    assign commit = AUTO || update_i;

    // Control FSM, shadow capture and atomic shadow-to-active transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            idx       <= 2'd0;
            for (int k = 0; k < int'(NTAP); k++) shadow[k] <= '0;
            coeff0_o  <= INIT0;
            coeff1_o  <= INIT1;
            coeff2_o  <= INIT2;
            coeff3_o  <= INIT3;
            s_ready_o <= 1'b1;
            pending_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (idx != 2'd3) begin
                            if (!s_last_i) begin
                                shadow[idx] <= s_dat_i;
                                idx         <= idx + 2'd1;
                                state       <= LOAD;
                            end else begin
                                // Short load: drop the partial set and restart.
                                for (int k = 0; k < int'(NTAP); k++) shadow[k] <= '0;
                                err_o <= 1'b1;
                                idx   <= 2'd0;
                                state <= IDLE;
                            end
                        end else if (s_last_i) begin
                            shadow[3] <= s_dat_i;
                            pending_o <= 1'b1;
                            s_ready_o <= 1'b0;
                            state     <= PENDING;
                        end else begin
                            err_o <= 1'b1;
                            idx   <= 2'd0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last_i) begin
                        state <= IDLE;
                    end
                end
                PENDING: begin
                    if (commit) begin
                        coeff0_o  <= shadow[0];
                        coeff1_o  <= shadow[1];
                        coeff2_o  <= shadow[2];
                        coeff3_o  <= shadow[3];
                        done_o    <= 1'b1;
                        pending_o <= 1'b0;
                        err_o     <= 1'b0;
                        s_ready_o <= 1'b1;
                        idx       <= 2'd0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: unit 0 uses manual commit, unit 1 auto commit.
module tb_fir_coeff_loader;

    localparam logic [71:0] INITS = {18'h00001, 18'h00002, 18'h00003, 18'h00004};
    localparam logic [71:0] CA    = {18'h1FFFF, 18'h00100, 18'h20000, 18'h3FFFF};
    localparam logic [71:0] CB    = {18'h00011, 18'h00022, 18'h00033, 18'h00044};
    localparam logic [71:0] CC    = {18'h0000A, 18'h0000B, 18'h0000C, 18'h0000D};
    localparam logic [71:0] CD    = {18'h15555, 18'h2AAAA, 18'h00001, 18'h3FFFE};

    typedef struct {
        int          reps;
        logic        v;
        logic [17:0] d;
        logic        l;
        logic        up;
        logic        rdy;
        logic        pend;
        logic        dn;
        logic        er;
        logic [71:0] cf;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [1:0]        valid;
    logic [1:0][17:0]  dat;
    logic [1:0]        last;
    logic [1:0]        upd;
    logic [1:0]        rdy;
    logic [1:0]        pend;
    logic [1:0]        dn;
    logic [1:0]        er;
    logic [1:0][17:0]  c0;
    logic [1:0][17:0]  c1;
    logic [1:0][17:0]  c2;
    logic [1:0][17:0]  c3;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    fir_coeff_loader #(
        .AUTO_COMMIT("FALSE"),
        .INIT0(18'h00001), .INIT1(18'h00002), .INIT2(18'h00003), .INIT3(18'h00004),
        .CLKTYPE("NONE")
    ) u_man (
        .clk_i(clk), .rst_i(rst),
        .s_dat_i(dat[0]), .s_valid_i(valid[0]), .s_last_i(last[0]), .s_ready_o(rdy[0]),
        .update_i(upd[0]),
        .coeff0_o(c0[0]), .coeff1_o(c1[0]), .coeff2_o(c2[0]), .coeff3_o(c3[0]),
        .pending_o(pend[0]), .done_o(dn[0]), .err_o(er[0])
    );

    fir_coeff_loader #(
        .AUTO_COMMIT("TRUE"),
        .INIT0(18'h00001), .INIT1(18'h00002), .INIT2(18'h00003), .INIT3(18'h00004),
        .CLKTYPE("NONE")
    ) u_auto (
        .clk_i(clk), .rst_i(rst),
        .s_dat_i(dat[1]), .s_valid_i(valid[1]), .s_last_i(last[1]), .s_ready_o(rdy[1]),
        .update_i(upd[1]),
        .coeff0_o(c0[1]), .coeff1_o(c1[1]), .coeff2_o(c2[1]), .coeff3_o(c3[1]),
        .pending_o(pend[1]), .done_o(dn[1]), .err_o(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input int u, input string tag, input logic e_rdy, input logic e_pend,
                             input logic e_dn, input logic e_er, input logic [71:0] cf);
        chk($sformatf("%s u%0d ready", tag, u),   18'(rdy[u]),  18'(e_rdy));
        chk($sformatf("%s u%0d pending", tag, u), 18'(pend[u]), 18'(e_pend));
        chk($sformatf("%s u%0d done", tag, u),    18'(dn[u]),   18'(e_dn));
        chk($sformatf("%s u%0d err", tag, u),     18'(er[u]),   18'(e_er));
        chk($sformatf("%s u%0d coeff0", tag, u),  c0[u], cf[71:54]);
        chk($sformatf("%s u%0d coeff1", tag, u),  c1[u], cf[53:36]);
        chk($sformatf("%s u%0d coeff2", tag, u),  c2[u], cf[35:18]);
        chk($sformatf("%s u%0d coeff3", tag, u),  c3[u], cf[17:0]);
    endtask

    // One clock: drive at the falling edge, check just after the rising edge.
    task automatic step(input int u, input string tag, input logic v, input logic [17:0] d,
                        input logic l, input logic up, input logic e_rdy, input logic e_pend,
                        input logic e_dn, input logic e_er, input logic [71:0] cf);
        @(negedge clk);
        valid[u] = v;
        dat[u]   = d;
        last[u]  = l;
        upd[u]   = up;
        @(posedge clk);
        #1;
        check_all(u, tag, e_rdy, e_pend, e_dn, e_er, cf);
    endtask

    task automatic add(input int reps, input logic v, input logic [17:0] d, input logic l,
                       input logic up, input logic e_rdy, input logic e_pend, input logic e_dn,
                       input logic e_er, input logic [71:0] cf);
        vec_t t;
        t.reps = reps; t.v = v; t.d = d; t.l = l; t.up = up;
        t.rdy = e_rdy; t.pend = e_pend; t.dn = e_dn; t.er = e_er; t.cf = cf;
        vecs.push_back(t);
    endtask

    initial begin
        // Manual-commit scenario table: reps, v, dat, last, update | ready, pending, done, err, coeffs
        add(1, 1, 18'h1FFFF, 0, 1,  1, 0, 0, 0, INITS);
        add(1, 1, 18'h00100, 0, 0,  1, 0, 0, 0, INITS);
        add(1, 1, 18'h20000, 0, 0,  1, 0, 0, 0, INITS);
        add(1, 1, 18'h3FFFF, 1, 1,  0, 1, 0, 0, INITS);
        add(1, 1, 18'h12345, 0, 0,  0, 1, 0, 0, INITS);
        add(9, 0, 18'h0,     0, 0,  0, 1, 0, 0, INITS);
        add(1, 0, 18'h0,     0, 1,  1, 0, 1, 0, CA);
        add(2, 0, 18'h0,     0, 0,  1, 0, 0, 0, CA);
        // short load
        add(1, 1, 18'h0AAAA, 0, 0,  1, 0, 0, 0, CA);
        add(1, 1, 18'h0BBBB, 1, 0,  1, 0, 0, 1, CA);
        add(1, 0, 18'h0,     0, 1,  1, 0, 0, 1, CA);
        add(1, 1, 18'h00011, 0, 0,  1, 0, 0, 1, CA);
        add(1, 1, 18'h00022, 0, 0,  1, 0, 0, 1, CA);
        add(1, 1, 18'h00033, 0, 0,  1, 0, 0, 1, CA);
        add(1, 1, 18'h00044, 1, 0,  0, 1, 0, 1, CA);
        add(1, 0, 18'h0,     0, 1,  1, 0, 1, 0, CB);
        add(1, 0, 18'h0,     0, 0,  1, 0, 0, 0, CB);
        // long load: six beats, all accepted, drained beats never reach outputs
        add(1, 1, 18'h3AAAA, 0, 0,  1, 0, 0, 0, CB);
        add(1, 1, 18'h3AAAB, 0, 0,  1, 0, 0, 0, CB);
        add(1, 1, 18'h3AAAC, 0, 0,  1, 0, 0, 0, CB);
        add(1, 1, 18'h3AAAD, 0, 0,  1, 0, 0, 1, CB);
        add(1, 1, 18'h3AAAE, 0, 1,  1, 0, 0, 1, CB);
        add(1, 1, 18'h3AAAF, 1, 0,  1, 0, 0, 1, CB);
        add(1, 0, 18'h0,     0, 0,  1, 0, 0, 1, CB);
        add(1, 1, 18'h0000A, 0, 0,  1, 0, 0, 1, CB);
        add(1, 1, 18'h0000B, 0, 0,  1, 0, 0, 1, CB);
        add(1, 1, 18'h0000C, 0, 0,  1, 0, 0, 1, CB);
        add(1, 1, 18'h0000D, 1, 0,  0, 1, 0, 1, CB);
        add(2, 0, 18'h0,     0, 0,  0, 1, 0, 1, CB);
        add(1, 0, 18'h0,     0, 1,  1, 0, 1, 0, CC);
        add(1, 0, 18'h0,     0, 0,  1, 0, 0, 0, CC);

        rst   = 1'b1;
        valid = '0;
        dat   = '0;
        last  = '0;
        upd   = '0;
        repeat (2) @(negedge clk);
        check_all(0, "reset", 1, 0, 0, 0, INITS);
        check_all(1, "reset", 1, 0, 0, 0, INITS);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                step(0, $sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].up,
                     vecs[i].rdy, vecs[i].pend, vecs[i].dn, vecs[i].er, vecs[i].cf);
            end
        end

        // Auto commit, update held high throughout: pending at N+1, new set and done at N+2.
        step(1, "auto b0",   1, 18'h15555, 0, 1,  1, 0, 0, 0, INITS);
        step(1, "auto b1",   1, 18'h2AAAA, 0, 1,  1, 0, 0, 0, INITS);
        step(1, "auto b2",   1, 18'h00001, 0, 1,  1, 0, 0, 0, INITS);
        step(1, "auto b3",   1, 18'h3FFFE, 1, 1,  0, 1, 0, 0, INITS);
        step(1, "auto n+2",  0, 18'h0,     0, 1,  1, 0, 1, 0, CD);
        step(1, "auto n+3",  0, 18'h0,     0, 1,  1, 0, 0, 0, CD);
        step(1, "auto n+4",  0, 18'h0,     0, 1,  1, 0, 0, 0, CD);

        // Async reset while a set is pending on the manual unit.
        step(0, "rst b0", 1, 18'h01111, 0, 0,  1, 0, 0, 0, CC);
        step(0, "rst b1", 1, 18'h02222, 0, 0,  1, 0, 0, 0, CC);
        step(0, "rst b2", 1, 18'h03333, 0, 0,  1, 0, 0, 0, CC);
        step(0, "rst b3", 1, 18'h04444, 1, 0,  0, 1, 0, 0, CC);
        @(negedge clk);
        valid[0] = 1'b0;
        last[0]  = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all(0, "async rst", 1, 0, 0, 0, INITS);
        check_all(1, "async rst", 1, 0, 0, 0, INITS);
        @(negedge clk);
        rst = 1'b0;
        step(0, "post rst upd", 0, 18'h0, 0, 1,  1, 0, 0, 0, INITS);
        step(0, "post rst",     0, 18'h0, 0, 0,  1, 0, 0, 0, INITS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
